// File: rtl/freq_monitor_pkg.sv
// Shared types and constants for the frequency monitor.
package freq_monitor_pkg;

  // Width of the polled count register and of the window bounds
  localparam int unsigned CountW = 32;

  // Default parameter values for the monitor
  localparam int unsigned DefPollCycles    = 50000;
  localparam int unsigned DefReadLatency   = 1;
  localparam int unsigned DefTimeoutCycles = 256;
  localparam int unsigned DefLockCount     = 4;
  localparam int unsigned DefAddrW         = 4;
  localparam int unsigned DefCsrAddr       = 0;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StReq,
    StLat,
    StEval
  } state_e;

  // Inclusive unsigned window test; an inverted window (lo > hi) never matches
  function automatic logic in_window(input logic [CountW-1:0] v,
                                     input logic [CountW-1:0] lo,
                                     input logic [CountW-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/freq_monitor_lock.sv
// Sample qualification: window compare, saturating lock hysteresis and status registers.
module freq_monitor_lock
  import freq_monitor_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = DefLockCount
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CountW-1:0] sample,
  input  logic              update,
  input  logic              clear,
  input  logic [CountW-1:0] freq_min,
  input  logic [CountW-1:0] freq_max,
  output logic [CountW-1:0] freq_value,
  output logic              in_range,
  output logic              clk_absent,
  output logic              locked
);

  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

  logic [CntW-1:0] lock_cnt_q;
  logic [CntW-1:0] lock_cnt_d;
  logic            hit;

  // Next lock count: saturate on in-window samples, restart on any miss
  always_comb begin
    hit        = in_window(sample, freq_min, freq_max);
    lock_cnt_d = '0;
    if (hit) begin
      if (lock_cnt_q == CntW'(LOCK_COUNT)) begin
        lock_cnt_d = lock_cnt_q;
      end else begin
        lock_cnt_d = lock_cnt_q + CntW'(1);
      end
    end
  end

  // Status registers; a bus timeout drops lock without touching the last sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= '0;
      locked     <= 1'b0;
      freq_value <= '0;
      in_range   <= 1'b0;
      clk_absent <= 1'b0;
    end else if (clear) begin
      lock_cnt_q <= '0;
      locked     <= 1'b0;
    end else if (update) begin
      lock_cnt_q <= lock_cnt_d;
      locked     <= (lock_cnt_d == CntW'(LOCK_COUNT));
      freq_value <= sample;
      in_range   <= hit;
      clk_absent <= (sample == '0);
    end
  end

endmodule

// File: rtl/freq_monitor.sv
// Periodic Avalon-MM poller of a frequency counter register with lock and alarm status.
module freq_monitor
  import freq_monitor_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = DefPollCycles,
  parameter int unsigned READ_LATENCY   = DefReadLatency,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned LOCK_COUNT     = DefLockCount,
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned CSR_ADDR       = DefCsrAddr
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              err_clear,
  input  logic [CountW-1:0] freq_min,
  input  logic [CountW-1:0] freq_max,
  output logic [ADDR_W-1:0] mst_address,
  output logic              mst_read,
  input  logic              mst_waitrequest,
  input  logic [CountW-1:0] mst_readdata,
  output logic [CountW-1:0] freq_value,
  output logic              freq_valid,
  output logic              in_range,
  output logic              locked,
  output logic              clk_absent,
  output logic              bus_timeout
);

  localparam int unsigned TimerW = $clog2(POLL_CYCLES);
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LatW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic                pending_q;
  logic [StallW-1:0]   stall_q;
  logic [LatW-1:0]     lat_q;
  logic [CountW-1:0]   sample_q;
  logic                tick;
  logic                take_tick;
  logic                timeout_hit;

  assign tick        = enable && (timer_q == TimerW'(POLL_CYCLES - 1));
  assign take_tick   = (state_q == StWait) && enable && pending_q;
  assign timeout_hit = (state_q == StReq) && mst_waitrequest &&
                       (stall_q == StallW'(TIMEOUT_CYCLES - 1));

  assign mst_read    = (state_q == StReq);
  assign mst_address = mst_read ? ADDR_W'(CSR_ADDR) : '0;

  // Poll period timer, parked at zero while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (!enable || tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  // Single pending-tick flag; ticks landing on a set flag are lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else if (take_tick) begin
      pending_q <= 1'b0;
    end else if (tick) begin
      pending_q <= 1'b1;
    end
  end

  // Read transaction sequencer with stall timeout and fixed-latency capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      stall_q    <= '0;
      lat_q      <= '0;
      sample_q   <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= (state_q == StEval);
      unique case (state_q)
        StIdle: begin
          if (enable) state_q <= StWait;
        end
        StWait: begin
          // Disable wins so a late tick cannot start a read after shutdown
          if (!enable) begin
            state_q <= StIdle;
          end else if (pending_q) begin
            state_q <= StReq;
            stall_q <= '0;
          end
        end
        StReq: begin
          if (!mst_waitrequest) begin
            state_q <= StLat;
            lat_q   <= '0;
          end else if (timeout_hit) begin
            state_q <= StWait;
          end else begin
            stall_q <= stall_q + StallW'(1);
          end
        end
        StLat: begin
          if (lat_q == LatW'(READ_LATENCY - 1)) begin
            sample_q <= mst_readdata;
            state_q  <= StEval;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StEval: begin
          state_q <= StWait;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout overrides a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_timeout <= 1'b0;
    end else if (timeout_hit) begin
      bus_timeout <= 1'b1;
    end else if (err_clear) begin
      bus_timeout <= 1'b0;
    end
  end

  freq_monitor_lock #(
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample_q),
    .update     (state_q == StEval),
    .clear      (timeout_hit),
    .freq_min   (freq_min),
    .freq_max   (freq_max),
    .freq_value (freq_value),
    .in_range   (in_range),
    .clk_absent (clk_absent),
    .locked     (locked)
  );

endmodule

// File: tb/tb_freq_monitor.sv
// Directed bench for freq_monitor: one L=1 instance and one L=3 instance.
module tb_freq_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        err_clear = 1'b0;
  logic [31:0] freq_min = 32'd148000;
  logic [31:0] freq_max = 32'd149000;

  logic        wr_a = 1'b0;
  logic [31:0] rd_a = 32'd0;
  logic [3:0]  addr_a;
  logic        read_a, valid_a, inr_a, lock_a, abs_a, bto_a;
  logic [31:0] val_a;

  logic        en_b = 1'b0;
  logic        wr_b = 1'b0;
  logic [31:0] rd_b = 32'd0;
  logic [3:0]  addr_b;
  logic        read_b, valid_b, inr_b, lock_b, abs_b, bto_b;
  logic [31:0] val_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freq_monitor #(
    .POLL_CYCLES    (100),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (256),
    .LOCK_COUNT     (3),
    .ADDR_W         (4),
    .CSR_ADDR       (5)
  ) dut_a (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .err_clear       (err_clear),
    .freq_min        (freq_min),
    .freq_max        (freq_max),
    .mst_address     (addr_a),
    .mst_read        (read_a),
    .mst_waitrequest (wr_a),
    .mst_readdata    (rd_a),
    .freq_value      (val_a),
    .freq_valid      (valid_a),
    .in_range        (inr_a),
    .locked          (lock_a),
    .clk_absent      (abs_a),
    .bus_timeout     (bto_a)
  );

  freq_monitor #(
    .POLL_CYCLES    (100),
    .READ_LATENCY   (3),
    .TIMEOUT_CYCLES (256),
    .LOCK_COUNT     (3),
    .ADDR_W         (4),
    .CSR_ADDR       (0)
  ) dut_b (
    .clk             (clk),
    .reset           (reset),
    .enable          (en_b),
    .err_clear       (err_clear),
    .freq_min        (freq_min),
    .freq_max        (freq_max),
    .mst_address     (addr_b),
    .mst_read        (read_b),
    .mst_waitrequest (wr_b),
    .mst_readdata    (rd_b),
    .freq_value      (val_b),
    .freq_valid      (valid_b),
    .in_range        (inr_b),
    .locked          (lock_b),
    .clk_absent      (abs_b),
    .bus_timeout     (bto_b)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Step to the next freq_valid on instance A; n = negedges taken, rise = n of first mst_read
  task automatic wait_valid(input int max, output int n, output int rise, output logic [3:0] addr);
    n    = 0;
    rise = -1;
    addr = 4'hf;
    do begin
      @(negedge clk);
      n++;
      if (read_a && rise < 0) begin
        rise = n;
        addr = addr_a;
      end
    end while (!valid_a && n < max);
    check1("valid_seen", valid_a, 1'b1);
  endtask

  task automatic wait_read_a(input int max);
    int c = 0;
    while (!read_a && c < max) begin
      @(negedge clk);
      c++;
    end
    check1("read_seen", read_a, 1'b1);
  endtask

  initial begin
    int n, rise, sc, vk, rb, vc, rc;
    logic [3:0] addr;
    logic saw;

    repeat (2) @(negedge clk);
    check1("rst_read", read_a, 1'b0);
    check32("rst_addr", 32'(addr_a), 32'd0);
    check1("rst_valid", valid_a, 1'b0);
    check32("rst_value", val_a, 32'd0);
    check1("rst_inrange", inr_a, 1'b0);
    check1("rst_locked", lock_a, 1'b0);
    check1("rst_absent", abs_a, 1'b0);
    check1("rst_timeout", bto_a, 1'b0);

    reset = 1'b0;
    rd_a  = 32'd148500;
    @(negedge clk);
    enable = 1'b1;

    // First poll: tick after 100 cycles, read one cycle later, valid three after read
    wait_valid(300, n, rise, addr);
    check32("first_period", 32'(n), 32'd104);
    check32("read_to_valid", 32'(n - rise), 32'd3);
    check32("read_addr", 32'(addr), 32'd5);
    check32("idle_addr", 32'(addr_a), 32'd0);
    check32("value1", val_a, 32'd148500);
    check1("inrange1", inr_a, 1'b1);
    check1("locked1", lock_a, 1'b0);
    check1("absent1", abs_a, 1'b0);
    wait_valid(300, n, rise, addr);
    check32("period2", 32'(n), 32'd100);
    check1("locked2", lock_a, 1'b0);
    wait_valid(300, n, rise, addr);
    check32("period3", 32'(n), 32'd100);
    check1("locked3", lock_a, 1'b1);
    @(negedge clk);
    check1("valid_one_cycle", valid_a, 1'b0);

    // Out-of-window sample drops lock at once
    rd_a = 32'd150000;
    wait_valid(300, n, rise, addr);
    check32("period_after_gap", 32'(n), 32'd99);
    check32("value_hi", val_a, 32'd150000);
    check1("inrange_hi", inr_a, 1'b0);
    check1("unlock_hi", lock_a, 1'b0);

    rd_a = 32'd148500;
    wait_valid(300, n, rise, addr);
    check1("relock_1", lock_a, 1'b0);
    wait_valid(300, n, rise, addr);
    check1("relock_2", lock_a, 1'b0);
    wait_valid(300, n, rise, addr);
    check1("relock_3", lock_a, 1'b1);

    // Dead clock
    rd_a = 32'd0;
    wait_valid(300, n, rise, addr);
    check1("absent_set", abs_a, 1'b1);
    check1("absent_inrange", inr_a, 1'b0);
    check1("absent_unlock", lock_a, 1'b0);
    rd_a = 32'd148500;
    wait_valid(300, n, rise, addr);
    check1("absent_clr", abs_a, 1'b0);
    check1("absent_clr_inrange", inr_a, 1'b1);

    // Inclusive window edges
    rd_a = 32'd149000;
    wait_valid(300, n, rise, addr);
    check1("edge_max", inr_a, 1'b1);
    check1("edge_max_locked", lock_a, 1'b0);
    rd_a = 32'd148000;
    wait_valid(300, n, rise, addr);
    check1("edge_min", inr_a, 1'b1);
    check1("edge_min_locked", lock_a, 1'b1);

    // Inverted window never matches
    freq_min = 32'd149000;
    freq_max = 32'd148000;
    rd_a     = 32'd148500;
    wait_valid(300, n, rise, addr);
    check1("inverted_inrange", inr_a, 1'b0);
    check1("inverted_locked", lock_a, 1'b0);
    freq_min = 32'd148000;
    freq_max = 32'd149000;
    for (int i = 0; i < 3; i++) wait_valid(300, n, rise, addr);
    check1("relock_before_timeout", lock_a, 1'b1);

    // Timeout: 256 stall cycles then read dropped, lock lost, no sample
    wr_a = 1'b1;
    wait_read_a(200);
    sc  = 0;
    saw = 1'b0;
    while (read_a && sc < 400) begin
      sc++;
      if (valid_a) saw = 1'b1;
      @(negedge clk);
    end
    check32("stall_cycles", 32'(sc), 32'd256);
    check1("stall_no_valid", saw | valid_a, 1'b0);
    check1("timeout_set", bto_a, 1'b1);
    check1("timeout_unlock", lock_a, 1'b0);
    wr_a = 1'b0;
    wait_valid(300, n, rise, addr);
    check32("after_timeout_value", val_a, 32'd148500);
    check1("timeout_sticky", bto_a, 1'b1);
    check1("after_timeout_locked", lock_a, 1'b0);

    // Timeout coinciding with err_clear keeps the flag
    wr_a = 1'b1;
    wait_read_a(200);
    sc = 0;
    while (read_a && sc < 400) begin
      sc++;
      if (sc == 256) err_clear = 1'b1;
      @(negedge clk);
    end
    err_clear = 1'b0;
    check32("stall_cycles2", 32'(sc), 32'd256);
    check1("timeout_beats_clear", bto_a, 1'b1);
    wr_a = 1'b0;
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check1("err_clear", bto_a, 1'b0);
    wait_valid(300, n, rise, addr);
    check32("drain_value", val_a, 32'd148500);

    // L=3 instance: 5 stall cycles, data must be the one presented 3 cycles after acceptance
    wr_b = 1'b1;
    en_b = 1'b1;
    begin
      int c = 0;
      while (!read_b && c < 200) begin
        @(negedge clk);
        c++;
      end
    end
    check1("b_read_seen", read_b, 1'b1);
    vk = -1;
    rb = 0;
    for (int k = 0; k < 14; k++) begin
      if (valid_b && vk < 0) vk = k;
      if (read_b) rb++;
      wr_b = (k < 5);
      rd_b = 32'd1000 + 32'(k);
      @(negedge clk);
    end
    en_b = 1'b0;
    check32("b_read_cycles", 32'(rb), 32'd6);
    check32("b_valid_offset", 32'(vk), 32'd10);
    check32("b_value", val_b, 32'd1008);
    check1("b_inrange", inr_b, 1'b0);

    // Disable during LAT: the read still completes, then polling stops
    wait_read_a(200);
    @(negedge clk);
    enable = 1'b0;
    vc = 0;
    rc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_a) vc++;
      if (read_a) rc++;
    end
    check32("drop_valid_count", 32'(vc), 32'd1);
    check32("drop_read_count", 32'(rc), 32'd0);

    // Asynchronous reset in the middle of a stalled read
    wr_a   = 1'b1;
    enable = 1'b1;
    wait_read_a(200);
    repeat (2) @(negedge clk);
    check1("pre_reset_read", read_a, 1'b1);
    check32("pre_reset_value", val_a, 32'd148500);
    #2 reset = 1'b1;
    #1;
    check1("arst_read", read_a, 1'b0);
    check32("arst_addr", 32'(addr_a), 32'd0);
    check32("arst_value", val_a, 32'd0);
    check1("arst_inrange", inr_a, 1'b0);
    check1("arst_locked", lock_a, 1'b0);
    check1("arst_valid", valid_a, 1'b0);
    check1("arst_absent", abs_a, 1'b0);
    check1("arst_timeout", bto_a, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    wr_a   = 1'b0;
    reset  = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_monitor.md
# freq_monitor

Avalon-MM read initiator that periodically polls a frequency counter's count register (counts of a sampled clock per 1 ms window, register address 0) and qualifies the result. It checks each sample against a programmable inclusive window and applies lock hysteresis. It also flags a dead clock (zero count) and bus timeouts. It sits in the system-clock domain next to each SDI/QSFP reference-clock counter and drives status/LED and alarm logic.

## Interface
- POLL_CYCLES, 50000: poll period in clk cycles (1 ms at 50 MHz); ≥ 8
- READ_LATENCY, 1: fixed cycles from read acceptance to valid readdata; 1..4
- TIMEOUT_CYCLES, 256: max cycles read may stall on waitrequest
- LOCK_COUNT, 4: consecutive in-window samples required to assert locked; ≥ 1
- ADDR_W, 4: initiator address width
- CSR_ADDR, 0: address of count register
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  polling enable
- err_clear  in  1  single-cycle clear of sticky bus_timeout
- freq_min  in  32  window low bound (inclusive, quasi-static)
- freq_max  in  32  window high bound (inclusive, quasi-static)
- mst_address  out  ADDR_W  CSR_ADDR while mst_read=1, else 0
- mst_read  out  1  read request
- mst_waitrequest  in  1  stall; tie 0 for targets without waitrequest
- mst_readdata  in  32  read data
- freq_value  out  32  last captured count
- freq_valid  out  1  one-cycle pulse per new sample
- in_range  out  1  last sample within window
- locked  out  1  lock status
- clk_absent  out  1  last sample == 0
- bus_timeout  out  1  sticky timeout flag

## Operation
- All outputs reset to 0; FSM to IDLE, all counters to 0.
- Tick timer: free-runs 0..POLL_CYCLES-1 while enable=1. Held at 0 when enable=0. Wrap produces tick. One pending-tick flag; a tick arriving while pending is already set is dropped.
- FSM states:
  - IDLE: enable=1 → WAIT.
  - WAIT: pending tick → REQ (clears pending). enable=0 → IDLE.
  - REQ: mst_read=1. Accepted on a cycle with mst_read=1, mst_waitrequest=0 → LAT. Stall counter reaching TIMEOUT_CYCLES → drop read, set bus_timeout, clear lock count and locked, no freq_valid, → WAIT.
  - LAT: count READ_LATENCY cycles; capture mst_readdata into sample register on the final cycle → EVAL.
  - EVAL: one cycle; update status → WAIT.
- Once in REQ/LAT, enable=0 does not abort; transaction completes, then FSM reaches IDLE via WAIT.
- Evaluation (unsigned 32-bit compares):
  - in_range = freq_min ≤ v ≤ freq_max; freq_min > freq_max → always 0.
  - clk_absent = (v == 0).
  - Lock count saturates at LOCK_COUNT; in-range increments, out-of-range clears to 0.
  - locked = 1 when count reaches LOCK_COUNT; cleared on the same update as any out-of-range sample.
- err_clear clears bus_timeout; a simultaneous new timeout wins (flag stays 1).

## Timing
- Acceptance in cycle A → sample captured at end of cycle A+READ_LATENCY → EVAL is cycle A+L+1.
- freq_value, in_range, clk_absent and locked update at end of EVAL; freq_valid is high for exactly the following cycle.
- READ_LATENCY=1, no stall: mst_read high 1 cycle; freq_valid 3 cycles after mst_read rose.
- Poll rate is fixed by the tick timer, independent of transaction length while transaction < POLL_CYCLES.
- Reset asserted mid-transaction: mst_read drops immediately (async); all status returns to 0.

## Structure
- freq_monitor_pkg: FSM state enum (IDLE, WAIT, REQ, LAT, EVAL), default parameter constants, 32-bit count width constant.
- One sub-module: freq_monitor_lock (window compare + saturating hysteresis counter + locked/clk_absent registers), driven by sample and update strobe.
- Top holds tick timer, pending flag, FSM, stall/latency counters, bus_timeout.

## Test plan
- POLL_CYCLES=100, L=1, LOCK_COUNT=3, window 148000..149000, target returns 148500, waitrequest=0 → freq_valid every 100 cycles; locked rises on 3rd freq_valid; freq_value=148500.
- Locked, then one sample of 150000 → in_range=0, locked=0 on that freq_valid; next three 148500 samples → locked again on third.
- Target returns 0 → clk_absent=1, in_range=0; next 148500 → clk_absent=0.
- waitrequest held high 300 cycles, TIMEOUT_CYCLES=256 → mst_read drops after 256 stall cycles, bus_timeout=1, locked=0, no freq_valid; err_clear → bus_timeout=0.
- L=3, waitrequest high 5 cycles then low → capture on 3rd cycle after acceptance; value matches readdata presented then, not earlier cycles.
- enable dropped during LAT → freq_valid still occurs once, FSM reaches IDLE, mst_read stays 0 thereafter; reset pulse mid-REQ → all outputs 0 immediately.
